cp0_exc_ctrl: RTL and testbench

- Exception/interrupt sequencer for the 5-stage MIPS pipeline; sits beside the MEM stage.
- Prioritises incoming fault flags and pending interrupts, and owns the CP0 Status/Cause/EPC/BadVAddr registers.
- Drives a multi-cycle pipeline flush, then a one-cycle PC redirect to the handler vector (exception) or EPC (eret).
- Serves mfc0/mtc0 accesses.

---
 rtl/cp0_pkg.sv | 47 ++++
 rtl/cp0_exc_ctrl_if.sv | 20 ++
 rtl/cp0_exc_prio.sv | 55 +++++
 rtl/cp0_exc_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// ============================================================================
// Module : cp0_pkg
// Brief  : Shared constants and types for the CP0 exception sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

    localparam logic [4:0] c_exc_int  = 5'd0;
    localparam logic [4:0] c_exc_adel = 5'd4;
    localparam logic [4:0] c_exc_ades = 5'd5;
    localparam logic [4:0] c_exc_sys  = 5'd8;
    localparam logic [4:0] c_exc_bp   = 5'd9;
    localparam logic [4:0] c_exc_ri   = 5'd10;
    localparam logic [4:0] c_exc_ov   = 5'd12;

    localparam logic [4:0] c_reg_badvaddr = 5'd8;
    localparam logic [4:0] c_reg_count    = 5'd9;
    localparam logic [4:0] c_reg_compare  = 5'd11;
    localparam logic [4:0] c_reg_status   = 5'd12;
    localparam logic [4:0] c_reg_cause    = 5'd13;
    localparam logic [4:0] c_reg_epc      = 5'd14;

    localparam int unsigned c_status_ie  = 0;
    localparam int unsigned c_status_exl = 1;
    localparam int unsigned c_status_bev = 22;
    localparam int unsigned c_cause_bd   = 31;

    localparam logic [31:0] c_status_rst   = 32'h0040_0000;
    // IE, EXL, IM and BEV are the only Status bits that hold state
    localparam logic [31:0] c_status_wmask = 32'h0040_FF03;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        BV_NONE = 2'd0,
        BV_PC   = 2'd1,
        BV_DATA = 2'd2
    } bv_sel_t;

endpackage

`default_nettype wire

// File: rtl/cp0_exc_ctrl_if.sv
// ============================================================================
// Module : cp0_exc_ctrl_if
// Brief  : mfc0/mtc0 access bus between the pipeline and CP0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cp0_exc_ctrl_if;
    import cp0_pkg::*;

    logic [4:0]  cp0_addr;
    logic        mtc0_we;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;

    modport master (output cp0_addr, output mtc0_we, output cp0_wdata, input  cp0_rdata);
    modport slave  (input  cp0_addr, input  mtc0_we, input  cp0_wdata, output cp0_rdata);
endinterface

`default_nettype wire

// File: rtl/cp0_exc_prio.sv
// ============================================================================
// Module : cp0_exc_prio
// Brief  : Fixed-priority encoder from fault flags / pending interrupt to
//          take strobe, ExcCode and BadVAddr source.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_exc_prio
    import cp0_pkg::*;
(
    input  logic       i_int_pending,
    input  logic       i_if_addr_fault,
    input  logic       i_ri_fault,
    input  logic       i_overflow,
    input  logic       i_syscall,
    input  logic       i_brk,
    input  logic       i_ld_addr_fault,
    input  logic       i_st_addr_fault,
    output logic       o_take,
    output logic [4:0] o_exc_code,
    output bv_sel_t    o_bv_sel
);

    always_comb begin
        o_take     = 1'b1;
        o_exc_code = c_exc_int;
        o_bv_sel   = BV_NONE;
        if (i_int_pending) begin
            o_exc_code = c_exc_int;
        end else if (i_if_addr_fault) begin
            o_exc_code = c_exc_adel;
            o_bv_sel   = BV_PC;
        end else if (i_ri_fault) begin
            o_exc_code = c_exc_ri;
        end else if (i_overflow) begin
            o_exc_code = c_exc_ov;
        end else if (i_syscall) begin
            o_exc_code = c_exc_sys;
        end else if (i_brk) begin
            o_exc_code = c_exc_bp;
        end else if (i_ld_addr_fault) begin
            o_exc_code = c_exc_adel;
            o_bv_sel   = BV_DATA;
        end else if (i_st_addr_fault) begin
            o_exc_code = c_exc_ades;
            o_bv_sel   = BV_DATA;
        end else begin
            o_take     = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
// ============================================================================
// Module : cp0_exc_ctrl
// Brief  : CP0 exception/interrupt sequencer: Status/Cause/EPC/BadVAddr,
//          flush + redirect sequencing. Optional timer via CP0_TIMER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_addr_fault,
    input  logic                 ri_fault,
    input  logic                 overflow,
    input  logic                 syscall,
    input  logic                 brk,
    input  logic                 ld_addr_fault,
    input  logic                 st_addr_fault,
    input  logic [31:0]          pc_in,
    input  logic [31:0]          bad_vaddr_in,
    input  logic                 delay_slot,
    input  logic                 eret,
    input  logic [5:0]           hw_int,
    cp0_exc_ctrl_if.slave        cp0_bus,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 exl,
    output logic [31:0]          epc_out
);

    localparam logic [3:0] c_flush_len = 4'(FLUSH_CYCLES);

    logic [31:0] r_status, r_epc, r_badvaddr, r_redirect_pc, w_redirect_pc_nxt;
    logic        r_bd, r_flush, w_flush_nxt, r_redirect_valid, w_redirect_valid_nxt;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exc_code, w_exc_code;
    logic [5:0]  r_hw_ip, w_ip_hi;
    logic [3:0]  r_cnt, w_cnt_nxt;
    state_t      r_state, w_state_nxt;
    bv_sel_t     w_bv_sel;
    logic        w_int_pending, w_take, w_take_en, w_eret_en, w_exl;
    logic        w_wr_status, w_wr_cause, w_wr_epc;
    logic [31:0] w_cause;

    assign w_exl         = r_status[c_status_exl];
    assign w_int_pending = r_status[c_status_ie] & ~w_exl & (|({w_ip_hi, r_ip_sw} & r_status[15:8]));
    assign w_take_en     = (r_state == ST_RUN) & w_take;
    assign w_eret_en     = (r_state == ST_RUN) & eret & ~w_take;
    assign w_cause       = {r_bd, 15'b0, w_ip_hi, r_ip_sw, 1'b0, r_exc_code, 2'b0};
    assign w_wr_status   = cp0_bus.mtc0_we & (cp0_bus.cp0_addr == c_reg_status);
    assign w_wr_cause    = cp0_bus.mtc0_we & (cp0_bus.cp0_addr == c_reg_cause);
    assign w_wr_epc      = cp0_bus.mtc0_we & (cp0_bus.cp0_addr == c_reg_epc);

    cp0_exc_prio u_prio (
        .i_int_pending   (w_int_pending),
        .i_if_addr_fault (if_addr_fault),
        .i_ri_fault      (ri_fault),
        .i_overflow      (overflow),
        .i_syscall       (syscall),
        .i_brk           (brk),
        .i_ld_addr_fault (ld_addr_fault),
        .i_st_addr_fault (st_addr_fault),
        .o_take          (w_take),
        .o_exc_code      (w_exc_code),
        .o_bv_sel        (w_bv_sel)
    );

    // Hardware interrupt lines are sampled every cycle and carry no reset value
    always_ff @(posedge clk) begin
        r_hw_ip <= hw_int;
    end

`ifdef CP0_TIMER_EN
    logic        r_tick, r_timer_int;
    logic [31:0] r_count, r_compare;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick      <= 1'b0;
            r_count     <= '0;
            r_compare   <= '0;
            r_timer_int <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
            if (r_tick) begin
                r_count <= r_count + 32'd1;
                if (r_count + 32'd1 == r_compare)
                    r_timer_int <= 1'b1;
            end
            if (cp0_bus.mtc0_we && cp0_bus.cp0_addr == c_reg_count)
                r_count <= cp0_bus.cp0_wdata;
            if (cp0_bus.mtc0_we && cp0_bus.cp0_addr == c_reg_compare) begin
                r_compare   <= cp0_bus.cp0_wdata;
                r_timer_int <= 1'b0;
            end
        end
    end

    assign w_ip_hi = {r_hw_ip[5] | r_timer_int, r_hw_ip[4:0]};
`else
    assign w_ip_hi = r_hw_ip;
`endif

    always_comb begin
        cp0_bus.cp0_rdata = '0;
        case (cp0_bus.cp0_addr)
            c_reg_badvaddr: cp0_bus.cp0_rdata = r_badvaddr;
            c_reg_status:   cp0_bus.cp0_rdata = r_status;
            c_reg_cause:    cp0_bus.cp0_rdata = w_cause;
            c_reg_epc:      cp0_bus.cp0_rdata = r_epc;
`ifdef CP0_TIMER_EN
            c_reg_count:    cp0_bus.cp0_rdata = r_count;
            c_reg_compare:  cp0_bus.cp0_rdata = r_compare;
`endif
            default:        cp0_bus.cp0_rdata = '0;
        endcase
    end

    // mtc0 effects are applied first so that a same-cycle take overrides them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status   <= c_status_rst;
            r_epc      <= '0;
            r_badvaddr <= '0;
            r_bd       <= 1'b0;
            r_ip_sw    <= '0;
            r_exc_code <= '0;
        end else begin
            if (w_wr_status)
                r_status <= (r_status & ~c_status_wmask) | (cp0_bus.cp0_wdata & c_status_wmask);
            if (w_wr_cause)
                r_ip_sw <= cp0_bus.cp0_wdata[9:8];
            if (w_wr_epc)
                r_epc <= cp0_bus.cp0_wdata;
            if (w_take_en) begin
                r_exc_code             <= w_exc_code;
                r_status[c_status_exl] <= 1'b1;
                if (!w_exl) begin
                    r_epc <= delay_slot ? (pc_in - 32'd4) : pc_in;
                    r_bd  <= delay_slot;
                end
                if (w_bv_sel == BV_PC)
                    r_badvaddr <= pc_in;
                else if (w_bv_sel == BV_DATA)
                    r_badvaddr <= bad_vaddr_in;
            end else if (w_eret_en) begin
                r_status[c_status_exl] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_RUN;
            r_cnt            <= '0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_flush          <= w_flush_nxt;
            r_redirect_valid <= w_redirect_valid_nxt;
            r_redirect_pc    <= w_redirect_pc_nxt;
        end
    end

    // r_cnt holds FLUSH_CYCLES..1 across the flush window; redirect lands on 1
    always_comb begin
        w_state_nxt          = r_state;
        w_cnt_nxt            = r_cnt;
        w_flush_nxt          = r_flush;
        w_redirect_valid_nxt = 1'b0;
        w_redirect_pc_nxt    = r_redirect_pc;
        case (r_state)
            ST_RUN: begin
                if (w_take_en || w_eret_en) begin
                    w_state_nxt          = ST_FLUSH;
                    w_cnt_nxt            = c_flush_len;
                    w_flush_nxt          = 1'b1;
                    w_redirect_valid_nxt = (c_flush_len == 4'd1);
                    w_redirect_pc_nxt    = w_take_en ? EXC_VECTOR : r_epc;
                end
            end
            ST_FLUSH: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_RUN;
                    w_flush_nxt = 1'b0;
                end else begin
                    w_redirect_valid_nxt = (r_cnt == 4'd2);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_flush_nxt = 1'b0;
            end
        endcase
    end

    assign flush          = r_flush;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign exl            = w_exl;
    assign epc_out        = r_epc;

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
// ============================================================================
// Module : tb_cp0_exc_ctrl
// Brief  : Self-checking bench for cp0_exc_ctrl; redirect targets are queued
//          when an exception/eret is driven and matched at each redirect.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cp0_exc_ctrl;

    localparam logic [31:0] c_vec = 32'hBFC0_0380;
    localparam int          c_fl  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_addr_fault = 0, ri_fault = 0, overflow = 0, syscall = 0, brk = 0;
    logic        ld_addr_fault = 0, st_addr_fault = 0, delay_slot = 0, eret = 0;
    logic [31:0] pc_in = '0, bad_vaddr_in = '0;
    logic [5:0]  hw_int = '0;
    logic        flush, redirect_valid, exl;
    logic [31:0] redirect_pc, epc_out;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl #(.EXC_VECTOR(c_vec), .FLUSH_CYCLES(c_fl)) dut (
        .clk(clk), .rst(rst),
        .if_addr_fault(if_addr_fault), .ri_fault(ri_fault), .overflow(overflow),
        .syscall(syscall), .brk(brk), .ld_addr_fault(ld_addr_fault),
        .st_addr_fault(st_addr_fault), .pc_in(pc_in), .bad_vaddr_in(bad_vaddr_in),
        .delay_slot(delay_slot), .eret(eret), .hw_int(hw_int), .cp0_bus(bus),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exl(exl), .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    logic [31:0] sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          fl_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            fl_cnt = 0;
        end else begin
            fl_cnt = flush ? fl_cnt + 1 : 0;
            if (redirect_valid) begin
                if (sb_q.size() == 0) begin
                    check("rv_unexpected", 32'd1, 32'd0);
                end else begin
                    check("redirect_pc", redirect_pc, sb_q.pop_front());
                    check("flush_len", 32'(fl_cnt), 32'(c_fl));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.cp0_addr = a;
        @(negedge clk);
        check(tag, bus.cp0_rdata, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_addr  = a;
        bus.cp0_wdata = d;
        bus.mtc0_we   = 1'b1;
        tick();
        bus.mtc0_we   = 1'b0;
    endtask

    task automatic wait_flush_done();
        for (int i = 0; i < 20 && flush; i++) tick();
        if (flush) check("flush_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_eret(input logic [31:0] exp_pc);
        eret = 1'b1;
        sb_q.push_back(exp_pc);
        tick();
        eret = 1'b0;
        wait_flush_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cp0_addr  = '0;
        bus.cp0_wdata = '0;
        bus.mtc0_we   = 1'b0;
        repeat (3) tick();
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_rv", 32'(redirect_valid), 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_exl", 32'(exl), 32'd0);
        check("rst_epc_out", epc_out, 32'd0);
        rst = 1'b0;
        tick();
        rd("rst_status", 5'd12, 32'h0040_0000);
        rd("rst_cause", 5'd13, 32'd0);
        rd("rst_epc", 5'd14, 32'd0);
        rd("rst_badva", 5'd8, 32'd0);
        rd("unmapped", 5'd3, 32'd0);

        // overflow, not in a delay slot
        pc_in = 32'h8000_0100; overflow = 1'b1;
        sb_q.push_back(c_vec);
        tick();
        overflow = 1'b0;
        wait_flush_done();
        rd("ov_cause", 5'd13, 32'h0000_0030);
        check("ov_exl", 32'(exl), 32'd1);
        check("ov_epc", epc_out, 32'h8000_0100);
        do_eret(32'h8000_0100);
        check("eret_exl", 32'(exl), 32'd0);

        // load fault in a delay slot
        pc_in = 32'h8000_0204; delay_slot = 1'b1; bad_vaddr_in = 32'h0000_1003; ld_addr_fault = 1'b1;
        sb_q.push_back(c_vec);
        tick();
        ld_addr_fault = 1'b0; delay_slot = 1'b0;
        wait_flush_done();
        rd("ld_cause", 5'd13, 32'h8000_0010);
        rd("ld_epc", 5'd14, 32'h8000_0200);
        rd("ld_badva", 5'd8, 32'h0000_1003);
        do_eret(32'h8000_0200);

        // ri + st together; syscall during the flush must be ignored
        pc_in = 32'h8000_0500; bad_vaddr_in = 32'h0000_2000; ri_fault = 1'b1; st_addr_fault = 1'b1;
        sb_q.push_back(c_vec);
        tick();
        ri_fault = 1'b0; st_addr_fault = 1'b0; syscall = 1'b1;
        tick();
        syscall = 1'b0;
        wait_flush_done();
        rd("ri_cause", 5'd13, 32'h0000_0028);
        rd("ri_badva", 5'd8, 32'h0000_1003);
        rd("ri_epc", 5'd14, 32'h8000_0500);

        // eret + brk while EXL=1: brk wins, EPC untouched
        pc_in = 32'h8000_0600; eret = 1'b1; brk = 1'b1;
        sb_q.push_back(c_vec);
        tick();
        eret = 1'b0; brk = 1'b0;
        wait_flush_done();
        rd("brk_cause", 5'd13, 32'h0000_0024);
        check("brk_exl", 32'(exl), 32'd1);
        rd("brk_epc", 5'd14, 32'h8000_0500);
        do_eret(32'h8000_0500);

        // hardware interrupt through IM2
        wr(5'd12, 32'h0000_0401);
        rd("int_status_wr", 5'd12, 32'h0000_0401);
        pc_in = 32'h8000_0700; hw_int = 6'b00_0001;
        sb_q.push_back(c_vec);
        for (int i = 0; i < 6 && !flush; i++) tick();
        if (!flush) check("int_timeout", 32'd0, 32'd1);
        hw_int = '0;
        wait_flush_done();
        rd("int_cause", 5'd13, 32'd0);
        rd("int_epc", 5'd14, 32'h8000_0700);
        rd("int_status", 5'd12, 32'h0000_0403);

        // interrupt masked while EXL=1
        begin
            logic seen;
            seen = 1'b0;
            hw_int = 6'b00_0001;
            repeat (4) begin tick(); if (flush) seen = 1'b1; end
            check("int_masked_exl", 32'(seen), 32'd0);
        end
        hw_int = '0;
        tick(); tick();
        do_eret(32'h8000_0700);

        // mtc0 EPC in the same cycle as a syscall take: exception wins
        pc_in = 32'h8000_0800; syscall = 1'b1;
        sb_q.push_back(c_vec);
        wr(5'd14, 32'h1234_5678);
        syscall = 1'b0;
        wait_flush_done();
        rd("mt_epc", 5'd14, 32'h8000_0800);
        rd("mt_cause", 5'd13, 32'h0000_0020);
        do_eret(32'h8000_0800);

        // mtc0 Status with a take: IE/IM from the write, EXL forced by the take
        pc_in = 32'h8000_0900; overflow = 1'b1;
        sb_q.push_back(c_vec);
        wr(5'd12, 32'h0000_FF00);
        overflow = 1'b0;
        wait_flush_done();
        rd("mt_status", 5'd12, 32'h0000_FF02);
        do_eret(32'h8000_0900);
        wr(5'd13, 32'h0000_0300);
        rd("sw_ip", 5'd13, 32'h0000_0330);
        wr(5'd13, 32'h0000_0000);

        // reset in the first flush cycle aborts the redirect
        pc_in = 32'h8000_0A00; overflow = 1'b1;
        tick();
        overflow = 1'b0;
        check("abort_flush_on", 32'(flush), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_flush", 32'(flush), 32'd0);
        check("abort_rv", 32'(redirect_valid), 32'd0);
        tick(); tick();
        rst = 1'b0;
        repeat (4) tick();
        rd("abort_status", 5'd12, 32'h0040_0000);
        check("abort_exl", 32'(exl), 32'd0);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
